// File: rtl/ram_clr_port.sv
// Memory-side stage after the RAM clear sequencer: clear/user write mux, inferred
// simple dual-port RAM, pipelined read port with stale flag, and clear-done pulse.
module ram_clr_port #(
  parameter int unsigned        G_ADDR   = 8,
  parameter int unsigned        G_DATA   = 16,
  parameter logic [G_DATA-1:0]  G_CLRVAL = '0,
  parameter int unsigned        G_RDLAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrwe,
  input  logic [G_ADDR-1:0] clraddr,
  input  logic              clrrdy,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [G_ADDR-1:0] wr_addr,
  input  logic [G_DATA-1:0] wr_data,
  input  logic              rd_en,
  input  logic [G_ADDR-1:0] rd_addr,
  output logic              rd_vld,
  output logic [G_DATA-1:0] rd_data,
  output logic              rd_stale,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 1 << G_ADDR;

  logic [G_DATA-1:0] mem [DEPTH];

  logic              mem_we;
  logic [G_ADDR-1:0] mem_waddr;
  logic [G_DATA-1:0] mem_wdata;

  logic              clrrdy_d,   clrrdy_q;
  logic              clr_done_d, clr_done_q;
  logic              s1_vld_d,   s1_vld_q;
  logic              s1_stale_d, s1_stale_q;
  logic [G_DATA-1:0] s1_data_d,  s1_data_q;

  // Clear writes always win; the user port only sees ready when the sequencer is idle.
  always_comb begin
    wr_rdy    = clrrdy & ~clrwe & ~rst;
    mem_we    = clrwe | (wr_vld & wr_rdy);
    mem_waddr = clrwe ? clraddr : wr_addr;
    mem_wdata = clrwe ? G_CLRVAL : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read data is taken from the pre-write array contents, giving read-first collisions.
  always_comb begin
    clrrdy_d   = clrrdy;
    clr_done_d = clrrdy & ~clrrdy_q;
    s1_vld_d   = rd_en;
    s1_stale_d = rd_en & ~clrrdy;
    s1_data_d  = rd_en ? mem[rd_addr] : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clrrdy_q   <= 1'b1;
      clr_done_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_stale_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      clrrdy_q   <= clrrdy_d;
      clr_done_q <= clr_done_d;
      s1_vld_q   <= s1_vld_d;
      s1_stale_q <= s1_stale_d;
      s1_data_q  <= s1_data_d;
    end
  end

  assign clr_done = clr_done_q;

  if (G_RDLAT >= 2) begin : g_lat2
    logic              s2_vld_d,   s2_vld_q;
    logic              s2_stale_d, s2_stale_q;
    logic [G_DATA-1:0] s2_data_d,  s2_data_q;

    always_comb begin
      s2_vld_d   = s1_vld_q;
      s2_stale_d = s1_stale_q;
      s2_data_d  = s1_vld_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld_q   <= 1'b0;
        s2_stale_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_vld_q   <= s2_vld_d;
        s2_stale_q <= s2_stale_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_vld   = s2_vld_q;
    assign rd_stale = s2_stale_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_vld   = s1_vld_q;
    assign rd_stale = s1_stale_q;
    assign rd_data  = s1_data_q;
  end

endmodule
